decode_prefix_stream: RTL and testbench
=======================================

// Module: decode_prefix_stream
// PURPOSE
//  Byte-serial front end of the instruction decoder. Consumes one instruction byte per cycle.
//  Strips legacy prefixes and records them as flags. Strips the 0x0F escape and flags it as
//  is_2byte. Packs the remaining body bytes into a zero-padded window, with byte 0 at [7:0].
//  Presents {unescaped_instr, is_2byte} to decode_opc_phase2 through a valid/ready handshake.
// PARAMETERS
//  MAX_BYTES     9   body window depth in bytes; window width = 8*MAX_BYTES (72 by default)
//  MAX_INSN_LEN  15  architectural length limit; applies to all accepted bytes (prefixes/escape/body)
// PORTS
//  clk              in   1    clock; all state updates on posedge
//  rst_n            in   1    synchronous, active-low reset
//  in_valid         in   1    in_byte is valid
//  in_ready         out  1    block accepts in_byte this cycle
//  in_byte          in   8    instruction byte, in program order
//  in_last          in   1    in_byte is the final byte of the instruction
//  out_valid        out  1    decoded bundle is valid
//  out_ready        in   1    downstream consumes the bundle
//  unescaped_instr  out  72   body bytes, prefixes and 0x0F removed; unused bytes are 0
//  is_2byte         out  1    a 0x0F escape preceded the opcode
//  opsize_ovr       out  1    0x66 seen
//  addrsize_ovr     out  1    0x67 seen
//  lock             out  1    0xF0 seen
//  rep              out  1    0xF3 is the last of {F2,F3} seen
//  repne            out  1    0xF2 is the last of {F2,F3} seen
//  seg_ovr          out  3    segment override: 0 none, 1 ES(26), 2 CS(2E), 3 SS(36), 4 DS(3E), 5 FS(64), 6 GS(65)
//  insn_len         out  4    total accepted bytes, including prefixes and escape
//  err_len          out  1    more than MAX_INSN_LEN bytes accepted
//  err_overflow     out  1    body longer than MAX_BYTES
//  err_empty        out  1    in_last arrived before any body byte
// BEHAVIOUR
//  Reset
//   - rst_n=0 at posedge: state=S_PFX; window, flags, counters and all outputs go to 0.
//   - Any partial instruction is discarded. Reset overrides every other event in that cycle.
//  Handshakes
//   - A byte is accepted when in_valid & in_ready.
//   - in_ready = (state != S_OUT); this is purely a function of state.
//   - The bundle transfers when out_valid & out_ready.
//  State S_PFX (expecting a prefix or the first opcode byte)
//   - Prefix byte {66,67,F0,F2,F3,26,2E,36,3E,64,65}: set the matching flag and stay in S_PFX.
//   - Later segment prefixes replace seg_ovr. F2 and F3 clear each other, so the last one wins.
//     Other repeated prefixes are idempotent.
//   - 0x0F: set is_2byte, store nothing, go to S_BODY.
//   - Any other byte: store it at body index 0, set idx=1, go to S_BODY.
//  State S_BODY
//   - Store the byte at index idx, then idx++.
//   - If idx >= MAX_BYTES: drop the byte, set err_overflow (sticky), and do not increment idx.
//   - A 0x0F or prefix value in S_BODY is ordinary body data.
//  Length and termination (every state except S_OUT)
//   - Every accepted byte does insn_len++, saturating at 15.
//   - Accepting a byte when insn_len==MAX_INSN_LEN sets err_len (sticky).
//   - An accepted byte with in_last=1 goes to S_OUT after it is processed.
//   - If no body byte is stored by then, err_empty=1. This covers in_last on a prefix or on the 0x0F.
//  State S_OUT
//   - out_valid=1; all outputs are registered and stable while out_ready=0.
//   - On the transfer: clear window, flags, counters and errors in the same edge, then go to S_PFX.
//  Latency and throughput
//   - out_valid rises on the cycle after the in_last byte is accepted.
//   - Minimum spacing is N+1 cycles per N-byte instruction, because in_ready drops for at least one cycle in S_OUT.
//  Output visibility
//   - Outside S_OUT the outputs reflect in-progress state and are don't-care.
//   - Downstream samples them only while out_valid=1.
//  Width rule: body byte k occupies unescaped_instr[8k+7:8k].
// TESTING
//  1. 66 0F AF C3(last) -> is_2byte=1, opsize_ovr=1, unescaped_instr=72'hC3AF, insn_len=4, no errors
//  2. F2 F3 A4(last) -> rep=1, repne=0, is_2byte=0, unescaped_instr=72'hA4, insn_len=3
//  3. 90(last) with out_ready=0 for 3 cycles -> out_valid and all outputs stable, in_ready=0,
//     next byte consumed only after the transfer
//  4. 14x 2E then 90(last) -> seg_ovr=2, insn_len=15, err_len=0;
//     15x 2E then 90(last) -> err_len=1, insn_len=15
//  5. Body 01..0A (10 bytes, last on 0A) -> err_overflow=1, unescaped_instr=72'h090807060504030201
//  6. rst_n=0 after accepting 66 0F -> next instruction 90(last) gives opsize_ovr=0, is_2byte=0,
//     unescaped_instr=72'h90, insn_len=1

Source files
------------

// File: rtl/decode_prefix_stream.sv
// Byte-serial prefix/escape stripper feeding decode_opc_phase2; bundle valid the cycle after in_last is accepted.
// Backpressure: in_ready is low while a bundle waits, and the bundle holds until out_ready.
module decode_prefix_stream #(
   parameter int MAX_BYTES    = 9,
   parameter int MAX_INSN_LEN = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_byte,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*MAX_BYTES-1:0] unescaped_instr,
   output logic                   is_2byte,
   output logic                   opsize_ovr,
   output logic                   addrsize_ovr,
   output logic                   lock,
   output logic                   rep,
   output logic                   repne,
   output logic [2:0]             seg_ovr,
   output logic [3:0]             insn_len,
   output logic                   err_len,
   output logic                   err_overflow,
   output logic                   err_empty
);

   localparam int               IDX_W     = $clog2(MAX_BYTES + 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(MAX_BYTES);
   localparam logic [3:0]       LEN_LIMIT = 4'(MAX_INSN_LEN);

   typedef enum logic [1:0] {S_PFX, S_BODY, S_OUT} state_t;

   typedef struct packed {
      logic       is_2byte;
      logic       opsize_ovr;
      logic       addrsize_ovr;
      logic       lock;
      logic       rep;
      logic       repne;
      logic [2:0] seg_ovr;
      logic       err_len;
      logic       err_overflow;
      logic       err_empty;
   } meta_t;

   state_t                 state_q, state_d;
   meta_t                  meta_q, meta_d;
   logic [8*MAX_BYTES-1:0] win_q, win_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [3:0]             len_q, len_d;

   always_comb begin
      state_d = state_q;
      meta_d  = meta_q;
      win_d   = win_q;
      idx_d   = idx_q;
      len_d   = len_q;
      case (state_q)
         S_OUT: begin
            if (out_ready) begin
               meta_d  = '0;
               win_d   = '0;
               idx_d   = '0;
               len_d   = '0;
               state_d = S_PFX;
            end
         end
         S_PFX, S_BODY: begin
            if (in_valid) begin
               if (len_q == LEN_LIMIT) meta_d.err_len = 1'b1;
               if (len_q != 4'hF) len_d = len_q + 4'd1;
               if (state_q == S_PFX) begin
                  case (in_byte)
                     8'h66: meta_d.opsize_ovr   = 1'b1;
                     8'h67: meta_d.addrsize_ovr = 1'b1;
                     8'hF0: meta_d.lock         = 1'b1;
                     8'hF2: begin meta_d.repne = 1'b1; meta_d.rep   = 1'b0; end
                     8'hF3: begin meta_d.rep   = 1'b1; meta_d.repne = 1'b0; end
                     8'h26: meta_d.seg_ovr = 3'd1;
                     8'h2E: meta_d.seg_ovr = 3'd2;
                     8'h36: meta_d.seg_ovr = 3'd3;
                     8'h3E: meta_d.seg_ovr = 3'd4;
                     8'h64: meta_d.seg_ovr = 3'd5;
                     8'h65: meta_d.seg_ovr = 3'd6;
                     8'h0F: begin
                        meta_d.is_2byte = 1'b1;
                        state_d         = S_BODY;
                     end
                     default: begin
                        win_d[7:0] = in_byte;
                        idx_d      = IDX_W'(1);
                        state_d    = S_BODY;
                     end
                  endcase
               end else if (idx_q < IDX_MAX) begin
                  win_d[8*idx_q +: 8] = in_byte;
                  idx_d               = idx_q + 1'b1;
               end else begin
                  meta_d.err_overflow = 1'b1;
               end
               // idx only stays zero if nothing reached the body window
               if (in_last) begin
                  state_d = S_OUT;
                  if (idx_d == '0) meta_d.err_empty = 1'b1;
               end
            end
         end
         default: state_d = S_PFX;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_PFX;
         meta_q  <= '0;
         win_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         meta_q  <= meta_d;
         win_q   <= win_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
      end
   end

   assign in_ready        = (state_q != S_OUT);
   assign out_valid       = (state_q == S_OUT);
   assign unescaped_instr = win_q;
   assign is_2byte        = meta_q.is_2byte;
   assign opsize_ovr      = meta_q.opsize_ovr;
   assign addrsize_ovr    = meta_q.addrsize_ovr;
   assign lock            = meta_q.lock;
   assign rep             = meta_q.rep;
   assign repne           = meta_q.repne;
   assign seg_ovr         = meta_q.seg_ovr;
   assign insn_len        = len_q;
   assign err_len         = meta_q.err_len;
   assign err_overflow    = meta_q.err_overflow;
   assign err_empty       = meta_q.err_empty;

endmodule

// File: tb/tb_decode_prefix_stream.sv
// Random and directed instruction streams against a whole-instruction reference model.
module tb_decode_prefix_stream;

   typedef logic [7:0] byte_q_t[$];

   typedef struct packed {
      logic [71:0] instr;
      logic        is_2byte;
      logic        opsize;
      logic        addrsize;
      logic        lock;
      logic        rep;
      logic        repne;
      logic [2:0]  seg;
      logic [3:0]  len;
      logic        err_len;
      logic        err_ovf;
      logic        err_empty;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [71:0] unescaped_instr;
   logic        is_2byte, opsize_ovr, addrsize_ovr, lock, rep, repne;
   logic [2:0]  seg_ovr;
   logic [3:0]  insn_len;
   logic        err_len, err_overflow, err_empty;
   res_t        dut_res;

   int   n_vec = 0;
   int   n_err = 0;
   int   ready_pct = 100;
   int   bubble_pct = 0;
   int   hold_req = 0;
   res_t exp_q[$];

   decode_prefix_stream dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .unescaped_instr(unescaped_instr), .is_2byte(is_2byte),
      .opsize_ovr(opsize_ovr), .addrsize_ovr(addrsize_ovr), .lock(lock),
      .rep(rep), .repne(repne), .seg_ovr(seg_ovr), .insn_len(insn_len),
      .err_len(err_len), .err_overflow(err_overflow), .err_empty(err_empty)
   );

   assign dut_res = {unescaped_instr, is_2byte, opsize_ovr, addrsize_ovr, lock, rep, repne,
                     seg_ovr, insn_len, err_len, err_overflow, err_empty};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Whole-instruction view: leading prefix run, optional escape, the rest is body.
   function automatic res_t model(input byte_q_t b);
      res_t r;
      int   n = b.size();
      int   p = 0;
      int   body;
      logic more;
      r    = '0;
      more = 1'b1;
      while (p < n && more) begin
         more = 1'b1;
         case (b[p])
            8'h66: r.opsize   = 1'b1;
            8'h67: r.addrsize = 1'b1;
            8'hF0: r.lock     = 1'b1;
            8'hF2: {r.rep, r.repne} = 2'b01;
            8'hF3: {r.rep, r.repne} = 2'b10;
            8'h26: r.seg = 3'd1;
            8'h2E: r.seg = 3'd2;
            8'h36: r.seg = 3'd3;
            8'h3E: r.seg = 3'd4;
            8'h64: r.seg = 3'd5;
            8'h65: r.seg = 3'd6;
            default: more = 1'b0;
         endcase
         if (more) p++;
      end
      if (p < n && b[p] == 8'h0F) begin
         r.is_2byte = 1'b1;
         p++;
      end
      body = n - p;
      for (int k = 0; k < body && k < 9; k++) r.instr[8*k +: 8] = b[p+k];
      r.err_ovf   = (body > 9);
      r.err_empty = (body == 0);
      r.len       = (n > 15) ? 4'd15 : 4'(n);
      r.err_len   = (n > 15);
      return r;
   endfunction

   task automatic send(input byte_q_t b, input bit with_last, input bit push);
      logic acc;
      int   cnt;
      if (push) exp_q.push_back(model(b));
      for (int i = 0; i < b.size(); i++) begin
         while ($urandom_range(99) < bubble_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_byte  = b[i];
         in_last  = with_last && (i == b.size() - 1);
         acc = 1'b0;
         cnt = 0;
         while (!acc && cnt < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cnt++;
         end
         if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: byte %0d not accepted, in_ready=%b required 1", i, in_ready);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int cnt = 0;
      while (exp_q.size() != 0 && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d bundles outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold_req > 0 && out_valid) begin
            out_ready = 1'b0;
            hold_req--;
         end else begin
            out_ready = ($urandom_range(99) < ready_pct);
         end
      end
   end

   initial begin
      logic hold_prev = 1'b0;
      logic lat_pend  = 1'b0;
      res_t prev_res  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_prev = 1'b0;
            lat_pend  = 1'b0;
            continue;
         end
         if (lat_pend) check("latency_out_valid", 96'(out_valid), 96'(1));
         if (out_valid) begin
            check("in_ready_in_out", 96'(in_ready), 96'(0));
            if (hold_prev) check("hold_stable", 96'(dut_res), 96'(prev_res));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_bundle: got %h, expected none", dut_res);
               end else begin
                  check("bundle", 96'(dut_res), 96'(exp_q.pop_front()));
               end
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_res  = dut_res;
         lat_pend  = in_valid && in_ready && in_last;
      end
   end

   initial begin
      byte_q_t    b;
      res_t       r;
      logic [7:0] pfx_tab [11];
      pfx_tab = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {out_valid, in_ready, dut_res}, {1'b0, 1'b1, 88'h0});
      rst_n = 1'b1;

      // Hand-computed pins on the reference model
      b = {8'h66, 8'h0F, 8'hAF, 8'hC3};
      r = model(b);
      check("pin_t1", 96'(r), 96'({72'hC3AF, 6'b110000, 3'd0, 4'd4, 3'b000}));
      b = {8'hF2, 8'hF3, 8'hA4};
      r = model(b);
      check("pin_t2", 96'(r), 96'({72'hA4, 6'b000010, 3'd0, 4'd3, 3'b000}));
      b = {};
      for (int i = 0; i < 10; i++) b.push_back(8'(i + 1));
      r = model(b);
      check("pin_t5", 96'(r), 96'({72'h090807060504030201, 6'b0, 3'd0, 4'd10, 3'b010}));
      b = {};
      for (int i = 0; i < 15; i++) b.push_back(8'h2E);
      b.push_back(8'h90);
      r = model(b);
      check("pin_t4b", 96'(r), 96'({72'h90, 6'b0, 3'd2, 4'd15, 3'b100}));

      @(posedge clk); #1;
      send('{8'h66, 8'h0F, 8'hAF, 8'hC3}, 1'b1, 1'b1);
      send('{8'hF2, 8'hF3, 8'hA4}, 1'b1, 1'b1);
      drain();
      hold_req = 3;
      send('{8'h90}, 1'b1, 1'b1);
      send('{8'h91}, 1'b1, 1'b1);
      drain();
      b = {};
      for (int i = 0; i < 14; i++) b.push_back(8'h2E);
      b.push_back(8'h90);
      send(b, 1'b1, 1'b1);
      b = {};
      for (int i = 0; i < 15; i++) b.push_back(8'h2E);
      b.push_back(8'h90);
      send(b, 1'b1, 1'b1);
      b = {};
      for (int i = 0; i < 10; i++) b.push_back(8'(i + 1));
      send(b, 1'b1, 1'b1);
      send('{8'h0F}, 1'b1, 1'b1);
      send('{8'h66, 8'h26}, 1'b1, 1'b1);
      drain();

      // Reset mid-instruction must discard the partial prefix/escape state
      send('{8'h66, 8'h0F}, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_mid_insn", {out_valid, in_ready, dut_res}, {1'b0, 1'b1, 88'h0});
      rst_n = 1'b1;
      @(posedge clk); #1;
      send('{8'h90}, 1'b1, 1'b1);
      drain();

      ready_pct  = 65;
      bubble_pct = 20;
      for (int t = 0; t < 200; t++) begin
         int np;
         int nb;
         b  = {};
         np = ($urandom_range(3) == 0) ? int'($urandom_range(16)) : int'($urandom_range(3));
         for (int i = 0; i < np; i++) b.push_back(pfx_tab[$urandom_range(10)]);
         if ($urandom_range(2) == 0) b.push_back(8'h0F);
         nb = int'($urandom_range(11));
         for (int i = 0; i < nb; i++) b.push_back(8'($urandom_range(255)));
         if (b.size() == 0) b.push_back(8'h90);
         send(b, 1'b1, 1'b1);
      end
      drain();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
